pu_or1k_pfpu32_addsub_arb: RTL and testbench

Issue controller and arbiter for the 3-stage pfpu32 add/sub pipeline. Shares the single pipeline between two requesters (port 0: main FPU issue, port 1: secondary client such as a compare/convert helper) using round-robin or fixed priority. Generates the pipeline's start, is_sub, operand-select, advance and flush controls, and carries requester ID and tag alongside each operation. Delivers results through a valid/ready handshake with whole-pipe backpressure.

---
 rtl/pu_or1k_pfpu32_addsub_arb.sv | 117 +++++++++++
 tb/tb_pu_or1k_pfpu32_addsub_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_or1k_pfpu32_addsub_arb.sv
// Issue controller and two-way arbiter for the 3-stage pfpu32 add/sub pipeline.
// Tracks per-stage valid/requester/tag and presents stage 3 through a valid/ready port.
module pu_or1k_pfpu32_addsub_arb #(
  parameter int TAG_W      = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             req0_valid_i,
  input  logic             req0_is_sub_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic             req1_is_sub_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             req1_ready_o,
  output logic             start_o,
  output logic             is_sub_o,
  output logic             sel_o,
  output logic             adv_o,
  output logic             flush_o,
  input  logic             add_rdy_i,
  output logic             rslt_valid_o,
  output logic             rslt_id_o,
  output logic [TAG_W-1:0] rslt_tag_o,
  input  logic             rslt_ready_i,
  output logic [1:0]       inflight_o,
  output logic             idle_o,
  output logic             err_o
);

  logic             v1, v2, v3;
  logic             id1, id2, id3;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic             last;
  logic             err;

  logic             gnt_id;
  logic [TAG_W-1:0] gnt_tag;
  logic             adv;
  logic             accept;

  // Whole-pipe stall: only a held result in stage 3 can stop the pipe.
  assign adv = ~v3 | rslt_ready_i;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    gnt_id = 1'b0;
    if (FIXED_PRIO != 0)
      gnt_id = ~req0_valid_i;
    else if (req0_valid_i && req1_valid_i)
      gnt_id = ~last;
    else
      gnt_id = req1_valid_i;
  end

  assign gnt_tag = gnt_id ? req1_tag_i : req0_tag_i;

  assign req0_ready_o = ~gnt_id & req0_valid_i & adv & ~flush_i & ~rst;
  assign req1_ready_o =  gnt_id & req1_valid_i & adv & ~flush_i & ~rst;
  assign accept       = req0_ready_o | req1_ready_o;

  assign start_o  = accept;
  assign is_sub_o = accept & (gnt_id ? req1_is_sub_i : req0_is_sub_i);
  assign sel_o    = accept ? gnt_id : last;
  assign adv_o    = adv;
  assign flush_o  = flush_i;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the shift is order-independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      last <= 1'b1;
      err  <= 1'b0;
    end else begin
      err <= err | (add_rdy_i ^ v3);
      if (flush_i) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        v3 <= 1'b0;
      end else if (adv) begin
        v1 <= accept;
        v2 <= v1;
        v3 <= v2;
        if (accept)
          last <= gnt_id;
      end
    end
  end

  // NOTE: the id/tag payload is not reset; it is only meaningful where the
  // matching valid bit is set, and the valid bits are reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      id1  <= gnt_id;
      tag1 <= gnt_tag;
      id2  <= id1;
      tag2 <= tag1;
      id3  <= id2;
      tag3 <= tag2;
    end
  end

  assign rslt_valid_o = v3;
  assign rslt_id_o    = id3;
  assign rslt_tag_o   = tag3;

  assign inflight_o = {1'b0, v1} + {1'b0, v2} + {1'b0, v3};
  assign idle_o     = ~(v1 | v2 | v3);
  assign err_o      = err;

endmodule

// File: tb/tb_pu_or1k_pfpu32_addsub_arb.sv
// Bench for the add/sub issue arbiter: directed vector tables, hand sequences for
// flush/error/reset, and random traffic against a slot-array reference model.
module tb_pu_or1k_pfpu32_addsub_arb;

  localparam int TAG_W = 4;

  logic clk;
  logic rst, flush, r0v, r0s, r1v, r1s, rr, inject;
  logic [TAG_W-1:0] r0t, r1t;

  logic rdy0, rdy1, start, is_sub, sel, adv, flush_o, rv, rid, idle, err;
  logic [TAG_W-1:0] rtag;
  logic [1:0] infl;
  logic add_rdy;

  logic fp_rdy0, fp_rdy1, fp_start, fp_is_sub, fp_sel, fp_adv, fp_flush_o;
  logic fp_rv, fp_rid, fp_idle, fp_err;
  logic [TAG_W-1:0] fp_rtag;
  logic [1:0] fp_infl;

  assign add_rdy = rv ^ inject;

  pu_or1k_pfpu32_addsub_arb #(.TAG_W(TAG_W), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .req0_valid_i(r0v), .req0_is_sub_i(r0s), .req0_tag_i(r0t), .req0_ready_o(rdy0),
    .req1_valid_i(r1v), .req1_is_sub_i(r1s), .req1_tag_i(r1t), .req1_ready_o(rdy1),
    .start_o(start), .is_sub_o(is_sub), .sel_o(sel), .adv_o(adv), .flush_o(flush_o),
    .add_rdy_i(add_rdy), .rslt_valid_o(rv), .rslt_id_o(rid), .rslt_tag_o(rtag),
    .rslt_ready_i(rr), .inflight_o(infl), .idle_o(idle), .err_o(err)
  );

  pu_or1k_pfpu32_addsub_arb #(.TAG_W(TAG_W), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .flush_i(flush),
    .req0_valid_i(r0v), .req0_is_sub_i(r0s), .req0_tag_i(r0t), .req0_ready_o(fp_rdy0),
    .req1_valid_i(r1v), .req1_is_sub_i(r1s), .req1_tag_i(r1t), .req1_ready_o(fp_rdy1),
    .start_o(fp_start), .is_sub_o(fp_is_sub), .sel_o(fp_sel), .adv_o(fp_adv), .flush_o(fp_flush_o),
    .add_rdy_i(fp_rv), .rslt_valid_o(fp_rv), .rslt_id_o(fp_rid), .rslt_tag_o(fp_rtag),
    .rslt_ready_i(rr), .inflight_o(fp_infl), .idle_o(fp_idle), .err_o(fp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: three pipeline slots, last-granted pointer and sticky error.
  typedef struct { bit v; bit id; bit [TAG_W-1:0] tag; } slot_t;
  slot_t pipe [3];
  bit m_last, m_err, model_ok;
  bit e_adv, e_r0, e_r1, e_acc, e_g, e_sub, e_sel;
  bit [1:0] e_infl;

  task automatic drive(input bit i_rst, input bit i_flush, input bit v0, input bit s0,
                       input bit [TAG_W-1:0] t0, input bit v1, input bit s1,
                       input bit [TAG_W-1:0] t1, input bit i_rr, input bit i_inj);
    rst = i_rst; flush = i_flush; r0v = v0; r0s = s0; r0t = t0;
    r1v = v1; r1s = s1; r1t = t1; rr = i_rr; inject = i_inj;
  endtask

  // Mid-cycle: evaluate the model's view of the cycle and compare every output.
  task automatic mid();
    int n;
    #4;
    if (r0v && r1v)      e_g = ~m_last;
    else if (r1v)        e_g = 1'b1;
    else                 e_g = 1'b0;
    e_adv = !pipe[2].v || rr;
    e_r0  = !rst && !flush && e_adv && r0v && !e_g;
    e_r1  = !rst && !flush && e_adv && r1v &&  e_g;
    e_acc = e_r0 || e_r1;
    e_sub = e_acc ? (e_g ? r1s : r0s) : 1'b0;
    e_sel = e_acc ? e_g : m_last;
    n = 0;
    for (int i = 0; i < 3; i++) if (pipe[i].v) n++;
    e_infl = 2'(n);
    check("rdy0", 32'(rdy0), 32'(e_r0));
    check("rdy1", 32'(rdy1), 32'(e_r1));
    check("start", 32'(start), 32'(e_acc));
    check("flush_o", 32'(flush_o), 32'(flush));
    if (model_ok) begin
      check("adv", 32'(adv), 32'(e_adv));
      check("is_sub", 32'(is_sub), 32'(e_sub));
      check("sel", 32'(sel), 32'(e_sel));
      check("rslt_valid", 32'(rv), 32'(pipe[2].v));
      if (pipe[2].v) begin
        check("rslt_id", 32'(rid), 32'(pipe[2].id));
        check("rslt_tag", 32'(rtag), 32'(pipe[2].tag));
      end
      check("inflight", 32'(infl), 32'(e_infl));
      check("idle", 32'(idle), 32'(e_infl == 0));
      check("err", 32'(err), 32'(m_err));
    end
  endtask

  task automatic edge_step();
    bit rdy_in;
    rdy_in = pipe[2].v ^ inject;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
      m_last = 1'b1;
      m_err = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_err = m_err | (rdy_in ^ pipe[2].v);
      if (flush) begin
        for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
      end else if (e_adv) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = '{v: e_acc, id: e_g, tag: (e_g ? r1t : r0t)};
        if (e_acc) m_last = e_g;
      end
    end
    #1;
  endtask

  typedef struct {
    bit rst, flush, v0, s0; bit [TAG_W-1:0] t0; bit v1, s1; bit [TAG_W-1:0] t1; bit rr;
    bit e_rdy0, e_rdy1, e_adv, e_rv, e_id; bit [TAG_W-1:0] e_tag; bit [1:0] e_infl;
    bit e_sub, e_sel;
  } vec_t;

  function automatic vec_t mk(bit a_rst, bit a_fl, bit v0, bit s0, bit [TAG_W-1:0] t0,
                              bit v1, bit s1, bit [TAG_W-1:0] t1, bit a_rr,
                              bit x0, bit x1, bit xadv, bit xrv, bit xid,
                              bit [TAG_W-1:0] xtag, bit [1:0] xinf, bit xsub, bit xsel);
    vec_t t;
    t = '{a_rst, a_fl, v0, s0, t0, v1, s1, t1, a_rr, x0, x1, xadv, xrv, xid, xtag, xinf, xsub, xsel};
    return t;
  endfunction

  vec_t tbl [$];

  initial begin
    vec_t t;
    model_ok = 1'b0;
    m_last = 1'b1;
    m_err = 1'b0;
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, id: 1'b0, tag: '0};

    // Single op from req0 (subtract, tag 5).
    tbl.push_back(mk(0,0,1,1,5,0,0,0,1, 1,0,1,0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,1,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,1,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,1,1,0,5,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,1,0,0,0,0,0,0));
    // Round-robin with both requesters always valid (req1 subtracts).
    tbl.push_back(mk(1,0,1,0,0,1,1,0,1, 0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,1,1,0,1, 1,0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,1,1,1,1, 0,1,1,0,0,0,1,1,1));
    tbl.push_back(mk(0,0,1,0,2,1,1,2,1, 1,0,1,0,0,0,2,0,0));
    tbl.push_back(mk(0,0,1,0,3,1,1,3,1, 0,1,1,1,0,0,3,1,1));
    tbl.push_back(mk(0,0,1,0,4,1,1,4,1, 1,0,1,1,1,1,3,0,0));
    tbl.push_back(mk(0,0,1,0,5,1,1,5,1, 0,1,1,1,0,2,3,1,1));
    tbl.push_back(mk(0,0,1,0,6,1,1,6,1, 1,0,1,1,1,3,3,0,0));
    // Backpressure: three ops, consumer stalls cycles 3..6, then drains.
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0,0,0,1, 1,0,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,2,0,0,0,1, 1,0,1,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,3,0,0,0,1, 1,0,1,0,0,0,2,0,0));
    for (int c = 3; c <= 6; c++)
      tbl.push_back(mk(0,0,1,0,4,0,0,0,0, 0,0,0,1,0,1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,1,1,0,1,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,1,1,0,2,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,1,1,0,3,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,1,0,0,0,0,0,0));

    // Reset with both requesters asserting: nothing may be accepted.
    drive(1,0,1,0,0,1,0,0,1,0); mid(); edge_step();
    drive(1,0,1,0,0,1,0,0,1,0); mid();
    check("rst_rslt_valid", 32'(rv), 32'd0);
    check("rst_inflight", 32'(infl), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdy0", 32'(rdy0), 32'd0);
    check("rst_rdy1", 32'(rdy1), 32'd0);
    edge_step();

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      drive(t.rst, t.flush, t.v0, t.s0, t.t0, t.v1, t.s1, t.t1, t.rr, 1'b0);
      mid();
      if (t.rst) begin
        check("tbl_rst_rdy0", 32'(rdy0), 32'd0);
        check("tbl_rst_rdy1", 32'(rdy1), 32'd0);
      end else begin
        check("tbl_rdy0", 32'(rdy0), 32'(t.e_rdy0));
        check("tbl_rdy1", 32'(rdy1), 32'(t.e_rdy1));
        check("tbl_start", 32'(start), 32'(t.e_rdy0 | t.e_rdy1));
        check("tbl_adv", 32'(adv), 32'(t.e_adv));
        check("tbl_rv", 32'(rv), 32'(t.e_rv));
        check("tbl_infl", 32'(infl), 32'(t.e_infl));
        check("tbl_idle", 32'(idle), 32'(t.e_infl == 0));
        check("tbl_err", 32'(err), 32'd0);
        if (t.e_rv) begin
          check("tbl_id", 32'(rid), 32'(t.e_id));
          check("tbl_tag", 32'(rtag), 32'(t.e_tag));
        end
        if (t.e_rdy0 || t.e_rdy1) begin
          check("tbl_is_sub", 32'(is_sub), 32'(t.e_sub));
          check("tbl_sel", 32'(sel), 32'(t.e_sel));
        end
        if (t.v0 && t.rr && !t.flush)
          check("fp_rdy0", 32'(fp_rdy0), 32'd1);
        if (t.v0)
          check("fp_rdy1", 32'(fp_rdy1), 32'd0);
      end
      edge_step();
    end

    // Flush with three ops in flight; flush coincides with a result handshake.
    drive(1,0,0,0,0,0,0,0,1,0); mid(); edge_step();
    drive(0,0,0,0,0,1,0,7,1,0); mid();
    check("fl_rdy1", 32'(rdy1), 32'd1);
    check("fp_only_req1", 32'(fp_rdy1), 32'd1);
    edge_step();
    drive(0,0,0,0,0,1,0,8,1,0); mid(); edge_step();
    drive(0,0,0,0,0,1,0,9,1,0); mid(); edge_step();
    drive(0,1,1,0,10,0,0,0,1,0); mid();
    check("fl_rdy0", 32'(rdy0), 32'd0);
    check("fl_flush_o", 32'(flush_o), 32'd1);
    check("fl_infl_before", 32'(infl), 32'd3);
    check("fl_rv_handshake", 32'(rv), 32'd1);
    check("fl_tag_handshake", 32'(rtag), 32'd7);
    edge_step();
    drive(0,0,0,0,0,0,0,0,1,0); mid();
    check("fl_infl_after", 32'(infl), 32'd0);
    check("fl_last_kept", 32'(sel), 32'd1);
    check("fl_rv0", 32'(rv), 32'd0);
    edge_step();
    drive(0,0,1,0,11,1,0,12,1,0); mid();
    check("fl_grant_after", 32'(rdy0), 32'd1);
    check("fl_rv1", 32'(rv), 32'd0);
    edge_step();
    for (int c = 0; c < 2; c++) begin
      drive(0,0,0,0,0,0,0,0,1,0); mid();
      check("fl_no_rslt", 32'(rv), 32'd0);
      edge_step();
    end
    drive(0,0,0,0,0,0,0,0,1,0); mid();
    check("fl_next_rv", 32'(rv), 32'd1);
    check("fl_next_tag", 32'(rtag), 32'd11);
    edge_step();

    // Error detect: add_rdy_i asserted while stage 3 is empty.
    drive(0,0,0,0,0,0,0,0,1,1); mid();
    check("err_before", 32'(err), 32'd0);
    edge_step();
    for (int c = 0; c < 3; c++) begin
      drive(0,0,0,0,0,0,0,0,1,0); mid();
      check("err_sticky", 32'(err), 32'd1);
      edge_step();
    end

    // Reset mid-stream with two ops in flight and err set.
    drive(0,0,1,0,1,0,0,0,1,0); mid(); edge_step();
    drive(0,0,1,0,2,0,0,0,1,0); mid(); edge_step();
    drive(1,0,1,0,3,1,0,4,1,0); mid();
    check("mr_infl", 32'(infl), 32'd2);
    check("mr_rdy0", 32'(rdy0), 32'd0);
    edge_step();
    drive(0,0,1,0,5,1,0,6,1,0); mid();
    check("mr_infl_after", 32'(infl), 32'd0);
    check("mr_rv", 32'(rv), 32'd0);
    check("mr_err", 32'(err), 32'd0);
    check("mr_grant0", 32'(rdy0), 32'd1);
    check("mr_grant1", 32'(rdy1), 32'd0);
    edge_step();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 127) == 0));
      mid();
      edge_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
